uart_param_tx: RTL and testbench

UART_PARAM_TX -- requirements
Module: uart_param_tx

---
 rtl/uart_param_tx_pkg.sv | 12 +
 rtl/uart_param_tx_if.sv | 23 ++
 rtl/uart_param_byte_sel.sv | 49 ++++
 rtl/uart_param_tx.sv | 100 ++++++++++
 tb/tb_uart_param_tx.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_param_tx_pkg.sv
// Shared UART packet definitions: FSM states, packet length and default header.
package uart_param_tx_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int PKT_LEN = 15;
  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

endpackage

// File: rtl/uart_param_tx_if.sv
// Byte stream towards the UART transmitter (valid/ready handshake).
interface uart_param_tx_if;

  logic [7:0] to_uart_data;
  logic       to_uart_valid;
  logic       to_uart_error;
  logic       to_uart_ready;

  modport master (
    output to_uart_data,
    output to_uart_valid,
    output to_uart_error,
    input  to_uart_ready
  );

  modport slave (
    input  to_uart_data,
    input  to_uart_valid,
    input  to_uart_error,
    output to_uart_ready
  );

endinterface

// File: rtl/uart_param_byte_sel.sv
// Combinational packet byte selector: header, selector, three big-endian words, XOR checksum.
module uart_param_byte_sel
  import uart_param_tx_pkg::*;
(
  input  logic [7:0]  header,
  input  logic [7:0]  sig_num,
  input  logic [31:0] adder,
  input  logic [31:0] amplitude,
  input  logic [31:0] sig,
  input  logic [3:0]  idx,
  output logic [7:0]  byte_out
);

  // Payload bytes 0..13; the checksum is kept separate so it never feeds back into the array.
  logic [7:0] pkt [PKT_LEN-1];
  logic [7:0] chk;

  assign pkt[0] = header;
  assign pkt[1] = sig_num;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_words
      assign pkt[2 + gi]  = adder[31 - 8*gi -: 8];
      assign pkt[6 + gi]  = amplitude[31 - 8*gi -: 8];
      assign pkt[10 + gi] = sig[31 - 8*gi -: 8];
    end
  endgenerate

  always_comb begin
    chk = 8'h00;
    for (int i = 0; i < PKT_LEN - 1; i++) begin
      chk = chk ^ pkt[i];
    end
  end

  always_comb begin
    byte_out = 8'h00;
    for (int i = 0; i < PKT_LEN - 1; i++) begin
      if (idx == 4'(i)) begin
        byte_out = pkt[i];
      end
    end
    if (idx == 4'(PKT_LEN - 1)) begin
      byte_out = chk;
    end
  end

endmodule

// File: rtl/uart_param_tx.sv
// Parameter snapshot packetiser: on start, freezes the inputs and streams a 15-byte packet.
module uart_param_tx
  import uart_param_tx_pkg::*;
#(
  parameter logic [7:0] HEADER = DEFAULT_HEADER
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [7:0]             signalNumber,
  input  logic [31:0]            adder,
  input  logic [31:0]            amplitude,
  input  logic [31:0]            signal,
  uart_param_tx_if.master        tx,
  output logic                   busy,
  output logic                   done
);

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic        done_q, done_d;
  logic [7:0]  sig_num_q, sig_num_d;
  logic [31:0] adder_q, adder_d;
  logic [31:0] amplitude_q, amplitude_d;
  logic [31:0] signal_q, signal_d;
  logic [7:0]  sel_byte;

  uart_param_byte_sel u_byte_sel (
    .header    (HEADER),
    .sig_num   (sig_num_q),
    .adder     (adder_q),
    .amplitude (amplitude_q),
    .sig       (signal_q),
    .idx       (idx_q),
    .byte_out  (sel_byte)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    done_d      = 1'b0;
    sig_num_d   = sig_num_q;
    adder_d     = adder_q;
    amplitude_d = amplitude_q;
    signal_d    = signal_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sig_num_d   = signalNumber;
          adder_d     = adder;
          amplitude_d = amplitude;
          signal_d    = signal;
          idx_d       = 4'd0;
          state_d     = SEND;
        end
      end
      SEND: begin
        // start is deliberately not looked at here, so requests while busy are dropped.
        if (tx.to_uart_ready) begin
          if (idx_q == 4'(PKT_LEN - 1)) begin
            idx_d   = 4'd0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      idx_q       <= 4'd0;
      done_q      <= 1'b0;
      sig_num_q   <= 8'h00;
      adder_q     <= 32'h0;
      amplitude_q <= 32'h0;
      signal_q    <= 32'h0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      done_q      <= done_d;
      sig_num_q   <= sig_num_d;
      adder_q     <= adder_d;
      amplitude_q <= amplitude_d;
      signal_q    <= signal_d;
    end
  end

  // Data is zero outside a packet; inside, it depends only on snapshot and index.
  assign tx.to_uart_data  = (state_q == SEND) ? sel_byte : 8'h00;
  assign tx.to_uart_valid = (state_q == SEND);
  assign tx.to_uart_error = 1'b0;
  assign busy             = (state_q == SEND);
  assign done             = done_q;

endmodule

// File: tb/tb_uart_param_tx.sv
// Directed bench for uart_param_tx: packet content, backpressure, isolation, ignored start, reset abort.
module tb_uart_param_tx;

  typedef logic [7:0] pkt_t [15];

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  signalNumber;
  logic [31:0] adder;
  logic [31:0] amplitude;
  logic [31:0] signal;
  logic        busy;
  logic        done;

  uart_param_tx_if tx_if ();

  uart_param_tx #(.HEADER(8'hA5)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .signalNumber (signalNumber),
    .adder        (adder),
    .amplitude    (amplitude),
    .signal       (signal),
    .tx           (tx_if.master),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] got [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic pkt_t model(input logic [7:0] sn, input logic [31:0] a,
                                 input logic [31:0] am, input logic [31:0] s);
    pkt_t p;
    logic [7:0] x;
    p[0] = 8'hA5;
    p[1] = sn;
    for (int i = 0; i < 4; i++) begin
      p[2 + i]  = a[31 - 8*i -: 8];
      p[6 + i]  = am[31 - 8*i -: 8];
      p[10 + i] = s[31 - 8*i -: 8];
    end
    x = 8'h00;
    for (int i = 0; i < 14; i++) x = x ^ p[i];
    p[14] = x;
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pkt(input logic [7:0] sn, input logic [31:0] a,
                           input logic [31:0] am, input logic [31:0] s);
    signalNumber = sn;
    adder        = a;
    amplitude    = am;
    signal       = s;
    start        = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // mode 0: ready=1; 1: random ready + 20-cycle stall at byte 7;
  // 2: inputs scrambled every cycle; 3: start pulses at byte 5 and byte 14; 4: reset at byte 9.
  task automatic capture(input int mode, input int budget, input bit restart,
                         output int n_done, output int vcycles);
    logic       r;
    logic       prev_stall;
    logic [7:0] prev_data;
    int         stall;
    got.delete();
    n_done = 0;
    vcycles = 0;
    prev_stall = 1'b0;
    prev_data = 8'h00;
    stall = 0;
    for (int c = 0; c < budget; c++) begin
      r = 1'b1;
      start = 1'b0;
      if (mode == 1) begin
        if (got.size() == 7 && stall < 20) begin
          r = 1'b0;
          stall++;
        end else begin
          r = 1'($urandom_range(0, 1));
        end
      end
      if (mode == 2) begin
        signalNumber = 8'($urandom);
        adder        = $urandom;
        amplitude    = $urandom;
        signal       = $urandom;
      end
      if (mode == 3 && tx_if.to_uart_valid && (got.size() == 5 || got.size() == 14))
        start = 1'b1;
      if (mode == 4 && tx_if.to_uart_valid && got.size() == 9) begin
        reset = 1'b0;
        tick();
        break;
      end
      tx_if.to_uart_ready = r;
      #1;
      if (prev_stall && tx_if.to_uart_valid)
        chk("stable_during_stall", {24'h0, tx_if.to_uart_data}, {24'h0, prev_data});
      if (done) begin
        n_done++;
        if (restart) start = 1'b1;
      end
      if (tx_if.to_uart_valid) vcycles++;
      if (tx_if.to_uart_valid && r) got.push_back(tx_if.to_uart_data);
      prev_stall = tx_if.to_uart_valid && !r;
      prev_data  = tx_if.to_uart_data;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (n_done > 0) break;
    end
  endtask

  task automatic check_pkt(input string tag, input pkt_t exp);
    chk({tag, "_len"}, got.size(), 15);
    for (int i = 0; i < 15; i++) begin
      if (i < got.size()) chk($sformatf("%s_b%0d", tag, i), {24'h0, got[i]}, {24'h0, exp[i]});
    end
    $display("pkt %s: %0d bytes captured", tag, got.size());
  endtask

  initial begin
    pkt_t basic_exp;
    pkt_t exp2;
    int   nd;
    int   vc;
    int   seen_v;
    int   seen_d;

    basic_exp = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00,
                  8'hFF, 8'hFF, 8'h12, 8'h34, 8'h56, 8'h78, 8'hBC};
    reset = 1'b0;
    start = 1'b0;
    signalNumber = 8'h00;
    adder = 32'h0;
    amplitude = 32'h0;
    signal = 32'h0;
    tx_if.to_uart_ready = 1'b1;
    repeat (3) tick();
    chk("rst_valid", {31'h0, tx_if.to_uart_valid}, 0);
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_done", {31'h0, done}, 0);
    chk("rst_data", {24'h0, tx_if.to_uart_data}, 0);
    chk("rst_error", {31'h0, tx_if.to_uart_error}, 0);
    reset = 1'b1;
    tick();

    // Basic packet, then back-to-back restart in the done cycle.
    start_pkt(8'h01, 32'h10, 32'hFFFF, 32'h12345678);
    chk("first_valid", {31'h0, tx_if.to_uart_valid}, 1);
    chk("first_busy", {31'h0, busy}, 1);
    signalNumber = 8'h22;
    adder = 32'hCAFEBABE;
    amplitude = 32'h01020304;
    signal = 32'h80000001;
    capture(0, 40, 1'b1, nd, vc);
    check_pkt("basic", basic_exp);
    chk("basic_valid_cycles", vc, 15);
    chk("basic_done_count", nd, 1);
    chk("b2b_done_one_cycle", {31'h0, done}, 0);
    chk("b2b_valid", {31'h0, tx_if.to_uart_valid}, 1);
    capture(0, 40, 1'b0, nd, vc);
    check_pkt("b2b", model(8'h22, 32'hCAFEBABE, 32'h01020304, 32'h80000001));
    chk("b2b_done_count", nd, 1);
    chk("after_done_low", {31'h0, done}, 0);
    chk("after_valid_low", {31'h0, tx_if.to_uart_valid}, 0);
    tick();

    // Backpressure.
    start_pkt(8'h01, 32'h10, 32'hFFFF, 32'h12345678);
    capture(1, 400, 1'b0, nd, vc);
    check_pkt("bp", basic_exp);
    chk("bp_done_count", nd, 1);
    tick();

    // Snapshot isolation.
    exp2 = model(8'h5C, 32'hDEADBEEF, 32'h00C0FFEE, 32'hA5A55A5A);
    start_pkt(8'h5C, 32'hDEADBEEF, 32'h00C0FFEE, 32'hA5A55A5A);
    capture(2, 40, 1'b0, nd, vc);
    check_pkt("iso", exp2);
    chk("iso_done_count", nd, 1);
    tick();

    // Ignored start during byte 5 and during the byte-14 transfer.
    start_pkt(8'h03, 32'h11223344, 32'h55667788, 32'h99AABBCC);
    capture(3, 40, 1'b0, nd, vc);
    check_pkt("ign", model(8'h03, 32'h11223344, 32'h55667788, 32'h99AABBCC));
    chk("ign_done_count", nd, 1);
    seen_v = 0;
    for (int i = 0; i < 5; i++) begin
      if (tx_if.to_uart_valid) seen_v++;
      tick();
    end
    chk("ign_no_second_pkt", seen_v, 0);
    start_pkt(8'h04, 32'h1, 32'h2, 32'h3);
    capture(0, 40, 1'b0, nd, vc);
    check_pkt("ign_next", model(8'h04, 32'h1, 32'h2, 32'h3));
    tick();

    // Reset mid-packet.
    start_pkt(8'h01, 32'h10, 32'hFFFF, 32'h12345678);
    capture(4, 40, 1'b0, nd, vc);
    chk("rstmid_bytes_before", got.size(), 9);
    chk("rstmid_no_done", nd, 0);
    chk("rstmid_valid", {31'h0, tx_if.to_uart_valid}, 0);
    chk("rstmid_busy", {31'h0, busy}, 0);
    chk("rstmid_done", {31'h0, done}, 0);
    chk("rstmid_data", {24'h0, tx_if.to_uart_data}, 0);
    reset = 1'b1;
    tx_if.to_uart_ready = 1'b1;
    seen_v = 0;
    seen_d = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (tx_if.to_uart_valid) seen_v++;
      if (done) seen_d++;
    end
    chk("rstmid_no_resume", seen_v, 0);
    chk("rstmid_no_done_after", seen_d, 0);
    start_pkt(8'h7E, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'h00000000);
    capture(0, 40, 1'b0, nd, vc);
    check_pkt("rstmid_new", model(8'h7E, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'h00000000));
    chk("rstmid_new_done", nd, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
